// File: rtl/ca_code_if.sv
`default_nettype none
// ============================================================================
// Module      : ca_code_if
// Description : Control and chip-output bundle of the GPS L1 C/A code
//               generator. The master side selects the PRN, advances the
//               code and receives the replica chip.
// Revision    : 1.0 - initial release
// ============================================================================
interface ca_code_if;
  logic       g2_init;  // 1: tap-select mode, 0: G2 initial-state mode
  logic [9:0] init;     // PRN selector, sampled while rst is high
  logic       rd;       // advance one chip per clock when high
  logic       chip;     // current code chip

  modport master (output g2_init, output init, output rd, input chip);
  modport slave  (input g2_init, input init, input rd, output chip);
endinterface
`default_nettype wire

// File: rtl/ca_code.sv
`default_nettype none
// ============================================================================
// Module      : ca_code
// Description : GPS L1 C/A (Gold) code generator. G1 (1+x^3+x^10) and G2
//               (1+x^2+x^3+x^6+x^8+x^9+x^10) are combined either through a
//               G2 phase-selector tap pair or through G2 stage 10 with an
//               explicit G2 start state. One chip per enabled clock; the
//               1023-chip epoch is enforced by a chip counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ca_code (
  input  logic       clk,
  input  logic       rst,
  ca_code_if.slave   bus
);

  localparam logic [9:0] C_LAST_CHIP = 10'd1022;

  // Stage k of each register lives at bit index k (stage 1 = feedback input).
  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  logic [10:1] g2_seed_q, g2_seed_d;   // G2 reload value for each epoch
  logic        mode_q, mode_d;         // 1: tap-select, 0: delay mode
  logic [3:0]  tap_a_q, tap_a_d;
  logic [3:0]  tap_b_q, tap_b_d;
  logic [9:0]  cnt_q, cnt_d;

  logic [10:1] w_seed;
  logic        w_g1_fb;
  logic        w_g2_fb;
  logic        w_tap_a_bit;
  logic        w_tap_b_bit;

  // G2 value loaded at reset; an all-zero start state would lock the LFSR.
  always_comb begin
    w_seed = '1;
    if (!bus.g2_init && (bus.init != 10'd0)) begin
      w_seed = bus.init;
    end
  end

  // Phase-selector taps; out-of-range tap numbers contribute nothing.
  always_comb begin
    w_tap_a_bit = 1'b0;
    w_tap_b_bit = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (tap_a_q == 4'(k)) w_tap_a_bit = g2_q[k];
      if (tap_b_q == 4'(k)) w_tap_b_bit = g2_q[k];
    end
  end

  assign w_g1_fb = g1_q[3] ^ g1_q[10];
  assign w_g2_fb = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];

  assign bus.chip = mode_q ? (g1_q[10] ^ w_tap_a_bit ^ w_tap_b_bit)
                           : (g1_q[10] ^ g2_q[10]);

  // Next-state for an advance: shift both LFSRs, or reload at the epoch end.
  always_comb begin
    g1_d      = g1_q;
    g2_d      = g2_q;
    cnt_d     = cnt_q;
    g2_seed_d = g2_seed_q;
    mode_d    = mode_q;
    tap_a_d   = tap_a_q;
    tap_b_d   = tap_b_q;
    if (bus.rd) begin
      if (cnt_q == C_LAST_CHIP) begin
        cnt_d = 10'd0;
        g1_d  = '1;
        g2_d  = g2_seed_q;
      end else begin
        cnt_d = cnt_q + 10'd1;
        g1_d  = {g1_q[9:1], w_g1_fb};
        g2_d  = {g2_q[9:1], w_g2_fb};
      end
    end
  end

  // State registers; reset captures the PRN selection and restarts at chip 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q      <= '1;
      g2_q      <= w_seed;
      g2_seed_q <= w_seed;
      mode_q    <= bus.g2_init;
      tap_a_q   <= bus.init[7:4];
      tap_b_q   <= bus.init[3:0];
      cnt_q     <= 10'd0;
    end else begin
      g1_q      <= g1_d;
      g2_q      <= g2_d;
      g2_seed_q <= g2_seed_d;
      mode_q    <= mode_d;
      tap_a_q   <= tap_a_d;
      tap_b_q   <= tap_b_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ca_code.sv
`default_nettype none
// ============================================================================
// Module      : tb_ca_code
// Description : Self-checking bench for ca_code. The reference sequences are
//               produced from the linear recurrences of the G1/G2 output
//               streams and compared chip by chip with the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_code;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ca_code_if bus ();

  ca_code dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_seq [0:1022];

  int prn_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int prn_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: u[n] is the stage-10 output at chip n; stage t at chip n is
  // u[n+10-t]. The polynomials give the output-stream recurrences directly.
  task automatic gen_ref(input bit tapmode, input int a, input int b, input logic [9:0] iv);
    bit g1u [0:1032];
    bit g2u [0:1032];
    bit c;
    for (int j = 0; j < 10; j++) begin
      g1u[j] = 1'b1;
      g2u[j] = (tapmode || iv == 10'd0) ? 1'b1 : iv[9-j];
    end
    for (int m = 0; m < 1023; m++) begin
      g1u[m+10] = g1u[m+7] ^ g1u[m];
      g2u[m+10] = g2u[m+8] ^ g2u[m+7] ^ g2u[m+4] ^ g2u[m+2] ^ g2u[m+1] ^ g2u[m];
    end
    for (int n = 0; n < 1023; n++) begin
      c = g1u[n];
      if (tapmode) begin
        if (a >= 1 && a <= 10) c ^= g2u[n+10-a];
        if (b >= 1 && b <= 10) c ^= g2u[n+10-b];
      end else begin
        c ^= g2u[n];
      end
      exp_seq[n] = c;
    end
  endtask

  task automatic do_reset(input bit mode, input logic [9:0] iv);
    bus.g2_init = mode;
    bus.init    = iv;
    rst         = 1'b1;
    tick();
    rst         = 1'b0;
  endtask

  // Advances n chips with rd=1 and compares each against the model.
  task automatic run_check(input string tag, input int n);
    int mism;
    mism   = 0;
    bus.rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (bus.chip !== exp_seq[i % 1023]) mism++;
      tick();
    end
    chk(tag, mism, 0);
  endtask

  initial begin
    logic [9:0] first10;
    logic [4:0] first5;
    logic [9:0] iv;
    bit         s [0:2045];
    int         diffs, ones, mism, idx, ta, tb;
    logic       prev;

    bus.g2_init = 1'b1;
    bus.init    = 10'd0;
    bus.rd      = 1'b0;

    // PRN 1 and PRN 2 known first ten chips
    do_reset(1'b1, {2'b00, 4'd2, 4'd6});
    chk("prn1_reset_chip", bus.chip, 1);
    bus.rd = 1'b1;
    for (int i = 0; i < 10; i++) begin first10[9-i] = bus.chip; tick(); end
    chk("prn1_first10", first10, 10'b1100100000);

    do_reset(1'b1, {2'b00, 4'd3, 4'd7});
    for (int i = 0; i < 10; i++) begin first10[9-i] = bus.chip; tick(); end
    chk("prn2_first10", first10, 10'b1110010000);

    // Full period of every PRN 1..32, reserved bits randomised
    for (int p = 0; p < 32; p++) begin
      gen_ref(1'b1, prn_a[p], prn_b[p], 10'd0);
      do_reset(1'b1, {2'($urandom), 4'(prn_a[p]), 4'(prn_b[p])});
      chk($sformatf("prn%0d_reset_chip", p + 1), bus.chip, 1);
      run_check($sformatf("prn%0d_period", p + 1), 1023);
    end

    // Period and balance for PRN 1; selector changes without reset ignored
    gen_ref(1'b1, 2, 6, 10'd0);
    do_reset(1'b1, {2'b00, 4'd2, 4'd6});
    bus.rd = 1'b1;
    mism = 0;
    for (int n = 0; n < 2046; n++) begin
      if (n == 700) begin
        bus.init    = 10'($urandom);
        bus.g2_init = 1'($urandom);
      end
      s[n] = bus.chip;
      if (s[n] !== exp_seq[n % 1023]) mism++;
      tick();
    end
    diffs = 0;
    ones  = 0;
    for (int n = 0; n < 1023; n++) begin
      if (s[n] != s[n+1023]) diffs++;
      if (s[n]) ones++;
    end
    chk("prn1_two_periods_vs_model", mism, 0);
    chk("prn1_periodicity", diffs, 0);
    chk("prn1_ones_per_period", ones, 512);

    // rd gating with a random PRN: held chip while rd=0, advance otherwise
    ta = prn_a[$urandom_range(0, 31)];
    tb = 10 - ta + 1;
    gen_ref(1'b1, ta, tb, 10'd0);
    do_reset(1'b1, {2'b00, 4'(ta), 4'(tb)});
    idx  = 0;
    mism = 0;
    prev = bus.chip;
    for (int c = 0; c < 3000; c++) begin
      if (bus.chip !== exp_seq[idx % 1023]) mism++;
      if (c > 0 && !bus.rd && bus.chip !== prev) mism++;
      prev   = bus.chip;
      bus.rd = ($urandom_range(0, 2) != 0);
      tick();
      if (bus.rd) idx++;
    end
    chk("rd_gating_stream", mism, 0);

    // Reset mid-sequence at chip 500 with rd held high
    gen_ref(1'b1, 2, 6, 10'd0);
    do_reset(1'b1, {2'b00, 4'd2, 4'd6});
    bus.rd = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    do_reset(1'b1, {2'b00, 4'd2, 4'd6});
    for (int i = 0; i < 5; i++) begin first5[4-i] = bus.chip; tick(); end
    chk("midreset_first5", first5, 5'b11001);
    do_reset(1'b1, {2'b00, 4'd2, 4'd6});
    run_check("midreset_period", 1023);

    // Delay mode: all ones, zero (lockup guard), random start states
    for (int t = 0; t < 5; t++) begin
      iv = (t == 0) ? 10'h3FF : (t == 1) ? 10'h000 : 10'($urandom);
      gen_ref(1'b0, 0, 0, iv);
      do_reset(1'b0, iv);
      chk($sformatf("delay_reset_chip_%03h", iv), bus.chip, (iv == 10'd0) ? 0 : {31'd0, ~iv[9]});
      run_check($sformatf("delay_stream_%03h", iv), 1100);
    end

    // Degenerate taps: out-of-range and equal taps give the bare G1 sequence
    gen_ref(1'b0, 0, 0, 10'h3FF);
    for (int i = 0; i < 1023; i++) exp_seq[i] = exp_seq[i];
    gen_ref(1'b1, 0, 11, 10'd0);
    do_reset(1'b1, {2'b00, 4'd0, 4'd11});
    run_check("tap_0_11_g1_only", 1023);
    ta = $urandom_range(1, 10);
    gen_ref(1'b1, ta, ta, 10'd0);
    do_reset(1'b1, {2'b00, 4'(ta), 4'(ta)});
    run_check("tap_equal_cancel", 1023);

    // Random tap pairs over the whole 4-bit range, crossing the epoch wrap
    for (int t = 0; t < 4; t++) begin
      ta = $urandom_range(0, 15);
      tb = $urandom_range(0, 15);
      gen_ref(1'b1, ta, tb, 10'd0);
      do_reset(1'b1, {2'($urandom), 4'(ta), 4'(tb)});
      run_check($sformatf("rand_taps_%0d_%0d", ta, tb), 1100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
